// File: rtl/frame_sync_pkg.sv
// Shared types and default framing constants for the frame sync controller.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int unsigned DEF_SYNC_LEN    = 4;
  localparam logic [3:0]  DEF_SYNC_WORD   = 4'b1101;
  localparam int unsigned DEF_PAYLOAD_LEN = 8;

endpackage

// File: rtl/frame_sync_ctrl_sync_match.sv
// Sync-word history, fill counter and comparator; match is combinational on the current bit.
module sync_match
  import frame_sync_pkg::*;
#(
  parameter int unsigned           SYNC_LEN  = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic seq_in,
  output logic match
);

  localparam int unsigned FW = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] hist;
  logic [SYNC_LEN-1:0] shifted;
  logic [FW-1:0]       fill;

  assign shifted = {hist[SYNC_LEN-2:0], seq_in};

  // The current bit counts toward the fill, so SYNC_LEN-1 earlier bits suffice.
  assign match = bit_valid && (shifted == SYNC_WORD) && (fill >= FW'(SYNC_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= shifted;
      if (fill != FW'(SYNC_LEN)) fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frames a serial stream: hunt for sync word, capture payload, hold it for the consumer.
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int unsigned           SYNC_LEN    = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD   = DEF_SYNC_WORD,
  parameter int unsigned           PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int unsigned           CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seq_in,
  input  logic                   bit_valid,
  output logic [PAYLOAD_LEN-1:0] frame_data,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   sync_seen,
  output logic                   in_frame,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned PCW = $clog2(PAYLOAD_LEN + 1);

  state_t                 state;
  logic [PCW-1:0]         bit_cnt;
  logic [PAYLOAD_LEN-1:0] payload_sr;
  logic [PAYLOAD_LEN-1:0] payload_next;
  logic                   raw_match;
  logic                   hunt_match;
  logic                   clear;

  // History is held clear outside HUNT so every return to HUNT starts fresh.
  assign clear        = (state != HUNT);
  assign hunt_match   = raw_match && (state == HUNT);
  assign payload_next = (payload_sr << 1) | PAYLOAD_LEN'(seq_in);

  sync_match #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_match (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bit_valid (bit_valid),
    .seq_in    (seq_in),
    .match     (raw_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      payload_sr  <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      sync_seen   <= 1'b0;
      in_frame    <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      sync_seen <= 1'b0;
      case (state)
        HUNT: begin
          if (hunt_match) begin
            state     <= PAYLOAD;
            bit_cnt   <= '0;
            sync_seen <= 1'b1;
            in_frame  <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (bit_valid) begin
            payload_sr <= payload_next;
            if (bit_cnt == PCW'(PAYLOAD_LEN - 1)) begin
              frame_data  <= payload_next;
              frame_valid <= 1'b1;
              in_frame    <= 1'b0;
              state       <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + PCW'(1);
            end
          end
        end
        HOLD: begin
          if (bit_valid && (drop_count != {CNT_W{1'b1}}))
            drop_count <= drop_count + CNT_W'(1);
          if (frame_ready) begin
            frame_valid <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
            state       <= HUNT;
          end
        end
        default: begin
          state       <= HUNT;
          frame_valid <= 1'b0;
          in_frame    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed self-checking bench for frame_sync_ctrl with default parameters.
module tb_frame_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_ready = 1'b0;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       sync_seen;
  logic       in_frame;
  logic [7:0] frame_count;
  logic [7:0] drop_count;

  int tests = 0;
  int failed = 0;
  int sync_cnt = 0;
  int fv_cnt = 0;

  always #5 clk = ~clk;

  frame_sync_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .seq_in      (seq_in),
    .bit_valid   (bit_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sync_seen   (sync_seen),
    .in_frame    (in_frame),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always @(negedge clk) begin
    if (reset) begin
      sync_cnt <= 0;
      fv_cnt   <= 0;
    end else begin
      if (sync_seen)   sync_cnt <= sync_cnt + 1;
      if (frame_valid) fv_cnt   <= fv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_valid = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    seq_in = b;
    bit_valid = 1'b1;
    tick(1);
    bit_valid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_sync(input int gap);
    send_bit(1'b1, gap);
    send_bit(1'b1, gap);
    send_bit(1'b0, gap);
    send_bit(1'b1, gap);
  endtask

  initial begin
    tick(2);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_sync_seen", sync_seen, 0);
    check("rst_counts", {frame_count, drop_count}, 0);
    reset = 1'b0;

    // Basic frame with consumer always ready
    frame_ready = 1'b1;
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("s1_no_early_sync", sync_seen, 0);
    send_bit(1'b1, 0);
    check("s1_sync_seen", sync_seen, 1);
    check("s1_in_frame", in_frame, 1);
    send_byte(8'hA5, 0);
    check("s1_frame_valid", frame_valid, 1);
    check("s1_frame_data", frame_data, 8'hA5);
    check("s1_in_frame_off", in_frame, 0);
    tick(1);
    check("s1_valid_drop", frame_valid, 0);
    check("s1_frame_count", frame_count, 1);
    check("s1_drop_count", drop_count, 0);
    check("s1_sync_pulses", sync_cnt, 1);
    check("s1_valid_cycles", fv_cnt, 1);

    // Overlapping sync 1,1,1,0,1
    do_reset();
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("ov_no_sync_4", sync_cnt, 0);
    send_bit(1'b1, 0);
    check("ov_sync_5", sync_seen, 1);
    send_byte(8'h3C, 0);
    check("ov_frame_data", frame_data, 8'h3C);
    tick(1);
    check("ov_frame_count", frame_count, 1);

    // False start 1,1,0,0,1,1,0,1
    do_reset();
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("fs_no_sync_7", sync_cnt, 0);
    send_bit(1'b1, 0);
    check("fs_sync_8", sync_seen, 1);
    send_byte(8'h5A, 0);
    check("fs_frame_data", frame_data, 8'h5A);
    tick(1);

    // Backpressure: frame held while bits are dropped
    do_reset();
    frame_ready = 1'b0;
    send_sync(0);
    send_byte(8'hFF, 0);
    check("bp_frame_valid", frame_valid, 1);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check("bp_frame_data", frame_data, 8'hFF);
    check("bp_still_valid", frame_valid, 1);
    check("bp_drop_count", drop_count, 3);
    check("bp_count_before", frame_count, 0);
    frame_ready = 1'b1;
    tick(1);
    check("bp_released", frame_valid, 0);
    check("bp_frame_count", frame_count, 1);
    check("bp_drop_final", drop_count, 3);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("bp_hunt_no_sync", sync_cnt, 1);
    send_bit(1'b1, 0);
    check("bp_hunt_resync", sync_seen, 1);
    check("bp_in_frame", in_frame, 1);

    // Sparse bit_valid: two idle cycles between bits
    do_reset();
    send_sync(2);
    check("sp_sync_pulses", sync_cnt, 1);
    send_byte(8'hA5, 2);
    check("sp_frame_data", frame_data, 8'hA5);
    check("sp_frame_count", frame_count, 1);
    check("sp_valid_cycles", fv_cnt, 1);

    // Reset in the middle of a payload
    do_reset();
    send_sync(0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("mr_in_frame", in_frame, 1);
    do_reset();
    check("mr_in_frame_clr", in_frame, 0);
    check("mr_valid_clr", frame_valid, 0);
    send_sync(0);
    send_byte(8'hA5, 0);
    check("mr_frame_data", frame_data, 8'hA5);
    check("mr_valid_once", fv_cnt, 0);
    tick(1);
    check("mr_frame_count", frame_count, 1);

    // Drop counter saturation
    do_reset();
    frame_ready = 1'b0;
    send_sync(0);
    send_byte(8'h81, 0);
    for (int i = 1; i <= 300; i++) begin
      send_bit(i[0], 0);
      if (i == 254) check("sat_drop_254", drop_count, 254);
      if (i == 255) check("sat_drop_255", drop_count, 255);
    end
    check("sat_drop_300", drop_count, 255);
    check("sat_data_held", frame_data, 8'h81);
    frame_ready = 1'b1;
    tick(1);
    check("sat_drop_after", drop_count, 255);
    check("sat_frame_count", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required less");
    $fatal(1, "timeout");
  end

endmodule
